// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: bus widths, mem_control
// bit positions, access size encodings and the stage FSM state type.
package mem_defs;

    localparam int EXE_MEM_W = 159;
    localparam int MEM_WB_W  = 156;

    // Bit positions inside mem_control[4:0]
    localparam int MC_LOAD    = 4;
    localparam int MC_STORE   = 3;
    localparam int MC_SIZE_HI = 2;
    localparam int MC_SIZE_LO = 1;
    localparam int MC_SIGN    = 0;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11   // treated as a word access
    } mem_size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_DONE = 2'b10
    } mem_state_e;

endpackage

// File: rtl/mem_access_if.sv
// Data-memory port of the memory-access stage.
//
// Handshake: the master raises dm_req with dm_addr/dm_wen/dm_wdata and keeps
// all four stable until the slave answers with dm_ack. dm_ack may arrive in
// the same cycle as the first dm_req. dm_rdata is only meaningful in the
// cycle dm_ack is high. There is no abort: a started request always waits
// for its ack. dm_wen == 0 marks a read.
interface mem_access_if;
    logic        dm_req;
    logic [3:0]  dm_wen;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    modport master (
        output dm_req, dm_wen, dm_addr, dm_wdata,
        input  dm_ack, dm_rdata
    );

    modport slave (
        input  dm_req, dm_wen, dm_addr, dm_wdata,
        output dm_ack, dm_rdata
    );
endinterface

// File: rtl/mem_access_align.sv
// Purely combinational lane logic: store byte enables and data replication,
// load lane extraction with sign/zero extension, and misalignment detect.
module mem_align
    import mem_defs::*;
(
    input  logic [4:0]  mem_control,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wen,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic      is_load;
    logic      is_store;
    logic      is_sign;
    mem_size_e size;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        raw_misalign;

    assign is_load  = mem_control[MC_LOAD];
    // A load bit wins if both are set, so such an op never writes memory.
    assign is_store = mem_control[MC_STORE] & ~mem_control[MC_LOAD];
    assign is_sign  = mem_control[MC_SIGN];
    assign size     = mem_size_e'(mem_control[MC_SIZE_HI:MC_SIZE_LO]);
    assign byte_v   = rdata[{addr[1:0], 3'b000} +: 8];
    assign half_v   = addr[1] ? rdata[31:16] : rdata[15:0];
    assign misalign = raw_misalign & (is_load | is_store);

    // Per-size lane steering for both directions plus alignment check.
    always_comb begin
        wen          = 4'b0000;
        wdata        = store_data;
        load_data    = rdata;
        raw_misalign = 1'b0;
        case (size)
            SZ_BYTE: begin
                if (is_store) wen = 4'b0001 << addr[1:0];
                wdata     = {4{store_data[7:0]}};
                load_data = is_sign ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
            end
            SZ_HALF: begin
                raw_misalign = addr[0];
                if (is_store) wen = addr[1] ? 4'b1100 : 4'b0011;
                wdata     = {2{store_data[15:0]}};
                load_data = is_sign ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
            end
            default: begin
                raw_misalign = (addr[1:0] != 2'b00);
                if (is_store) wen = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: runs the data-memory handshake for loads and
// stores, flags misaligned accesses, and packs the MEM->WB bus.
module mem_access
    import mem_defs::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 MEM_valid,
    input  logic [EXE_MEM_W-1:0] EXE_MEM_bus_r,
    input  logic                 MEM_out_fire,
    input  logic                 cancel,
    output logic                 MEM_over,
    output logic [MEM_WB_W-1:0]  MEM_WB_bus,
    output logic [4:0]           MEM_wdest,
    output logic [31:0]          MEM_pc,
    mem_access_if.master         dm,
    output mem_state_e           dbg_state
);

    logic [4:0]  mem_control;
    logic [31:0] store_data;
    logic [31:0] exe_result;
    logic [31:0] lo_result;
    logic        hi_write, lo_write, mfhi, mflo, mtc0, mfc0;
    logic [7:0]  cp0r_addr;
    logic        syscall, eret, rf_wen;
    logic [4:0]  rf_wdest;
    logic [31:0] pc;
    logic        br, flagout, notinst, ri;

    assign {mem_control, store_data, exe_result, lo_result,
            hi_write, lo_write, mfhi, mflo, mtc0, mfc0, cp0r_addr,
            syscall, eret, rf_wen, rf_wdest, pc,
            br, flagout, notinst, ri} = EXE_MEM_bus_r;

    mem_state_e  state, state_nx;
    logic        cancel_r, cancel_nx;
    logic [31:0] rdata_r;
    logic        capture;
    logic        req_c;

    logic [3:0]  wen;
    logic [31:0] wdata;
    logic [31:0] load_data;
    logic        misalign;
    logic        is_mem;
    logic        start;
    logic        adel, ades;
    logic [31:0] mem_result;
    logic [31:0] badvaddr;

    mem_align u_align (
        .mem_control (mem_control),
        .addr        (exe_result),
        .store_data  (store_data),
        .rdata       (rdata_r),
        .wen         (wen),
        .wdata       (wdata),
        .load_data   (load_data),
        .misalign    (misalign)
    );

    assign is_mem = mem_control[MC_LOAD] | mem_control[MC_STORE];
    assign start  = MEM_valid & is_mem & ~misalign & ~cancel;

    // State, pending-cancel flag and captured read data.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_IDLE;
            cancel_r <= 1'b0;
            rdata_r  <= 32'h0;
        end else begin
            state    <= state_nx;
            cancel_r <= cancel_nx;
            if (capture) rdata_r <= dm.dm_rdata;
        end
    end

    // Next state, request strobe and completion; a cancelled request still
    // waits for its ack but then drops the data and never reports done.
    always_comb begin
        state_nx  = state;
        cancel_nx = cancel_r;
        capture   = 1'b0;
        req_c     = 1'b0;
        MEM_over  = 1'b0;
        case (state)
            S_IDLE: begin
                cancel_nx = 1'b0;
                if (start) state_nx = S_REQ;
                else       MEM_over = MEM_valid;
            end
            S_REQ: begin
                req_c = 1'b1;
                if (cancel) cancel_nx = 1'b1;
                if (dm.dm_ack) begin
                    cancel_nx = 1'b0;
                    if (cancel | cancel_r) begin
                        state_nx = S_IDLE;
                    end else begin
                        capture  = 1'b1;
                        state_nx = S_DONE;
                    end
                end
            end
            S_DONE: begin
                MEM_over = 1'b1;
                if (MEM_out_fire | cancel) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign dm.dm_req   = req_c;
    assign dm.dm_wen   = wen;
    assign dm.dm_addr  = {exe_result[31:2], 2'b00};
    assign dm.dm_wdata = wdata;

    assign adel       = misalign & mem_control[MC_LOAD];
    assign ades       = misalign & ~mem_control[MC_LOAD];
    assign badvaddr   = misalign ? exe_result : 32'h0;
    assign mem_result = mem_control[MC_LOAD] ? load_data : exe_result;

    assign MEM_WB_bus = {mem_result, lo_result,
                         hi_write, lo_write, mfhi, mflo, mtc0, mfc0, cp0r_addr,
                         syscall, eret, rf_wen, rf_wdest, pc,
                         br, flagout, notinst, ri,
                         adel, ades, badvaddr};

    assign MEM_wdest = rf_wdest & {5{MEM_valid}};
    assign MEM_pc    = pc;
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed vector table, hand-written
// cancel/reset/backpressure sequences, and randomized ops against a model.
module tb_mem_access;
    import mem_defs::*;

    logic clk = 1'b0;
    logic resetn, MEM_valid, MEM_out_fire, cancel;
    logic MEM_over;
    logic [155:0] MEM_WB_bus;
    logic [4:0]   MEM_wdest;
    logic [31:0]  MEM_pc;
    mem_state_e   dbg_state;

    always #5 clk = ~clk;

    // EXE->MEM fields
    logic [4:0]  f_ctrl;
    logic [31:0] f_sd, f_exe, f_lo, f_pc;
    logic [5:0]  f_misc6;
    logic [7:0]  f_cp0;
    logic [2:0]  f_se3;
    logic [4:0]  f_wdest;
    logic [3:0]  f_tail4;
    logic [158:0] exe_bus;
    assign exe_bus = {f_ctrl, f_sd, f_exe, f_lo, f_misc6, f_cp0, f_se3, f_wdest, f_pc, f_tail4};

    // MEM->WB fields
    logic [31:0] o_result, o_lo, o_pc, o_badv;
    logic [5:0]  o_misc6;
    logic [7:0]  o_cp0;
    logic [2:0]  o_se3;
    logic [4:0]  o_wdest;
    logic [3:0]  o_tail4;
    logic        o_adel, o_ades;
    assign {o_result, o_lo, o_misc6, o_cp0, o_se3, o_wdest, o_pc, o_tail4,
            o_adel, o_ades, o_badv} = MEM_WB_bus;

    mem_access_if dm_if ();

    mem_access dut (
        .clk          (clk),
        .resetn       (resetn),
        .MEM_valid    (MEM_valid),
        .EXE_MEM_bus_r(exe_bus),
        .MEM_out_fire (MEM_out_fire),
        .cancel       (cancel),
        .MEM_over     (MEM_over),
        .MEM_WB_bus   (MEM_WB_bus),
        .MEM_wdest    (MEM_wdest),
        .MEM_pc       (MEM_pc),
        .dm           (dm_if.master),
        .dbg_state    (dbg_state)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0]  ctrl;
        logic [31:0] addr, sd, rd;
        int          delay;
        logic [31:0] exp_result;
        logic [3:0]  exp_wen;
        logic [31:0] exp_wdata;
        logic        exp_adel, exp_ades;
    } vec_t;

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [4:0] c);
        case (c[2:1])
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic model_mis(input logic [4:0] c, input logic [31:0] a);
        if (!(c[4] | c[3])) return 1'b0;
        return (a % nbytes(c)) != 0;
    endfunction

    function automatic logic [31:0] model_result(input logic [4:0] c, input logic [31:0] a,
                                                 input logic [31:0] rd);
        int n, off;
        logic [31:0] mask, v;
        if (!c[4]) return a;
        n = nbytes(c);
        off = (a % 4) - ((a % 4) % n);
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 1);
        v = (rd >> (8 * off)) & mask;
        if (c[0] && n < 4 && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] model_wen(input logic [4:0] c, input logic [31:0] a);
        int n;
        if (c[4] || !c[3]) return 4'b0;
        n = nbytes(c);
        return 4'(((1 << n) - 1) << ((a % 4) - ((a % 4) % n)));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [4:0] c, input logic [31:0] sd);
        case (nbytes(c))
            1:       return {24'h0, sd[7:0]} * 32'h0101_0101;
            2:       return {16'h0, sd[15:0]} * 32'h0001_0001;
            default: return sd;
        endcase
    endfunction

    function automatic vec_t model_vec(input logic [4:0] c, input logic [31:0] a,
                                       input logic [31:0] sd, input logic [31:0] rd, input int d);
        vec_t v;
        logic mis;
        mis = model_mis(c, a);
        v.ctrl = c; v.addr = a; v.sd = sd; v.rd = rd; v.delay = d;
        v.exp_result = model_result(c, a, rd);
        v.exp_wen    = model_wen(c, a);
        v.exp_wdata  = model_wdata(c, sd);
        v.exp_adel   = mis & c[4];
        v.exp_ades   = mis & c[3] & ~c[4];
        return v;
    endfunction

    // ---------------- driver / checker for one op ----------------
    task automatic run_op(input vec_t v, input int hold, input string tag);
        int over_cyc, req_n, exp_lat, exp_req;
        logic stable, goes_mem;
        logic [3:0]  s_wen;
        logic [31:0] s_addr, s_wdata, s_res;
        f_ctrl = v.ctrl; f_exe = v.addr; f_sd = v.sd;
        f_lo = $urandom; f_pc = $urandom; f_misc6 = 6'($urandom); f_cp0 = 8'($urandom);
        f_se3 = 3'($urandom); f_wdest = 5'($urandom_range(1, 31)); f_tail4 = 4'($urandom);
        MEM_valid = 1'b1;
        goes_mem = (v.ctrl[4] | v.ctrl[3]) & ~(v.exp_adel | v.exp_ades);
        exp_lat = goes_mem ? 2 + v.delay : 0;
        exp_req = goes_mem ? v.delay + 1 : 0;
        over_cyc = -1; req_n = 0; stable = 1'b1;
        s_wen = '0; s_addr = '0; s_wdata = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (dm_if.dm_req) begin
                if (req_n == 0) begin
                    s_wen = dm_if.dm_wen; s_addr = dm_if.dm_addr; s_wdata = dm_if.dm_wdata;
                end else if (s_wen !== dm_if.dm_wen || s_addr !== dm_if.dm_addr ||
                             s_wdata !== dm_if.dm_wdata) begin
                    stable = 1'b0;
                end
                if (req_n == v.delay) begin
                    dm_if.dm_ack = 1'b1;
                    dm_if.dm_rdata = v.rd;
                end
                req_n++;
            end
            if (MEM_over) begin
                over_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
            dm_if.dm_ack = 1'b0;
            dm_if.dm_rdata = $urandom;
        end
        check({tag, " over_latency"}, over_cyc, exp_lat);
        check({tag, " req_cycles"}, req_n, exp_req);
        check({tag, " adel"}, {31'h0, o_adel}, {31'h0, v.exp_adel});
        check({tag, " ades"}, {31'h0, o_ades}, {31'h0, v.exp_ades});
        check({tag, " badvaddr"}, o_badv, (v.exp_adel | v.exp_ades) ? v.addr : 32'h0);
        if (!v.exp_adel) check({tag, " mem_result"}, o_result, v.exp_result);
        check({tag, " wdest"}, {27'h0, MEM_wdest}, {27'h0, f_wdest});
        check({tag, " pc"}, MEM_pc, f_pc);
        check({tag, " passthru"}, {6'h0, o_misc6, o_cp0, o_se3, o_wdest, o_tail4} ^ o_lo ^ o_pc,
              {6'h0, f_misc6, f_cp0, f_se3, f_wdest, f_tail4} ^ f_lo ^ f_pc);
        if (goes_mem) begin
            check({tag, " dm_addr"}, s_addr, v.addr & 32'hFFFF_FFFC);
            check({tag, " dm_wen"}, {28'h0, s_wen}, {28'h0, v.exp_wen});
            if (v.ctrl[3] && !v.ctrl[4]) check({tag, " dm_wdata"}, s_wdata, v.exp_wdata);
            check({tag, " req_stable"}, {31'h0, stable}, 32'h1);
        end
        s_res = o_result;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            dm_if.dm_ack = 1'b0;
            dm_if.dm_rdata = $urandom;
            @(negedge clk);
            check({tag, " over_hold"}, {31'h0, MEM_over}, 32'h1);
            check({tag, " result_hold"}, o_result, s_res);
        end
        MEM_out_fire = 1'b1;
        @(posedge clk); #1;
        MEM_out_fire = 1'b0;
        MEM_valid = 1'b0;
        dm_if.dm_ack = 1'b0;
        @(negedge clk);
        check({tag, " over_drop"}, {31'h0, MEM_over}, 32'h0);
        if (over_cyc < 0) begin
            resetn = 1'b0;
            @(posedge clk); #1;
            resetn = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    vec_t vecs[16];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; MEM_valid = 1'b0; MEM_out_fire = 1'b0; cancel = 1'b0;
        dm_if.dm_ack = 1'b0; dm_if.dm_rdata = 32'h0;
        f_ctrl = 5'b10100; f_sd = 0; f_exe = 32'h0000_1000; f_lo = 0; f_pc = 32'hBFC0_0000;
        f_misc6 = 0; f_cp0 = 0; f_se3 = 0; f_wdest = 5'd7; f_tail4 = 0;

        // -------- reset state --------
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset dm_req", {31'h0, dm_if.dm_req}, 32'h0);
        check("reset MEM_over", {31'h0, MEM_over}, 32'h0);
        check("reset state", 32'(dbg_state), 32'(S_IDLE));
        check("reset rdata_r", o_result, 32'h0);
        check("reset wdest gated", {27'h0, MEM_wdest}, 32'h0);
        @(posedge clk); #1;
        resetn = 1'b1;

        // -------- directed table --------
        vecs[0]  = '{5'b10001, 32'h1003, 32'h0,        32'h80FF1234, 0, 32'hFFFFFF80, 4'h0, 32'h0,        1'b0, 1'b0};
        vecs[1]  = '{5'b01010, 32'h2002, 32'h0000BEEF, 32'h0,        0, 32'h00002002, 4'hC, 32'hBEEFBEEF, 1'b0, 1'b0};
        vecs[2]  = '{5'b10100, 32'h1001, 32'h0,        32'h0,        0, 32'h0,        4'h0, 32'h0,        1'b1, 1'b0};
        vecs[3]  = '{5'b00000, 32'h12345678, 32'h5,    32'h0,        0, 32'h12345678, 4'h0, 32'h0,        1'b0, 1'b0};
        vecs[4]  = '{5'b10000, 32'h1003, 32'h0,        32'h80FF1234, 1, 32'h00000080, 4'h0, 32'h0,        1'b0, 1'b0};
        vecs[5]  = '{5'b10011, 32'h1002, 32'h0,        32'h80FF1234, 0, 32'hFFFF80FF, 4'h0, 32'h0,        1'b0, 1'b0};
        vecs[6]  = '{5'b10010, 32'h1000, 32'h0,        32'h80FF1234, 2, 32'h00001234, 4'h0, 32'h0,        1'b0, 1'b0};
        vecs[7]  = '{5'b10001, 32'h1000, 32'h0,        32'h80FF1234, 0, 32'h00000034, 4'h0, 32'h0,        1'b0, 1'b0};
        vecs[8]  = '{5'b01000, 32'h3001, 32'h12345678, 32'h0,        1, 32'h00003001, 4'h2, 32'h78787878, 1'b0, 1'b0};
        vecs[9]  = '{5'b01100, 32'h4000, 32'hDEADBEEF, 32'h0,        0, 32'h00004000, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[10] = '{5'b01100, 32'h4002, 32'hDEADBEEF, 32'h0,        0, 32'h00004002, 4'h0, 32'h0,        1'b0, 1'b1};
        vecs[11] = '{5'b01010, 32'h4001, 32'h0000BEEF, 32'h0,        0, 32'h00004001, 4'h0, 32'h0,        1'b0, 1'b1};
        vecs[12] = '{5'b10110, 32'h5004, 32'h0,        32'hCAFEF00D, 0, 32'hCAFEF00D, 4'h0, 32'h0,        1'b0, 1'b0};
        vecs[13] = '{5'b10011, 32'h1001, 32'h0,        32'h0,        0, 32'h0,        4'h0, 32'h0,        1'b1, 1'b0};
        vecs[14] = '{5'b01000, 32'h3003, 32'h000000A5, 32'h0,        0, 32'h00003003, 4'h8, 32'hA5A5A5A5, 1'b0, 1'b0};
        vecs[15] = '{5'b10001, 32'h1002, 32'h0,        32'h80FF1234, 0, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0, 1'b0};
        for (int i = 0; i < 16; i++) run_op(vecs[i], 0, $sformatf("vec%0d", i));

        // -------- delayed ack, result held until fire --------
        run_op(model_vec(5'b10100, 32'h0000_1000, 32'h0, 32'h1357_2468, 5), 3, "slow_lw");

        // -------- cancel while request outstanding --------
        f_ctrl = 5'b10100; f_exe = 32'h6000; MEM_valid = 1'b1;
        @(negedge clk);
        check("cancel cyc0 req", {31'h0, dm_if.dm_req}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("cancel req up", {31'h0, dm_if.dm_req}, 32'h1);
        @(posedge clk); #1;
        cancel = 1'b1;
        @(negedge clk);
        check("cancel req held", {31'h0, dm_if.dm_req}, 32'h1);
        @(posedge clk); #1;
        cancel = 1'b0; MEM_valid = 1'b0;
        @(negedge clk);
        check("cancel req still", {31'h0, dm_if.dm_req}, 32'h1);
        check("cancel no over", {31'h0, MEM_over}, 32'h0);
        dm_if.dm_ack = 1'b1; dm_if.dm_rdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        dm_if.dm_ack = 1'b0;
        @(negedge clk);
        check("cancel state idle", 32'(dbg_state), 32'(S_IDLE));
        check("cancel req drop", {31'h0, dm_if.dm_req}, 32'h0);
        check("cancel over low", {31'h0, MEM_over}, 32'h0);
        check("cancel data dropped", o_result, 32'h1357_2468);
        @(posedge clk); #1;

        // -------- reset in the middle of a request --------
        f_ctrl = 5'b10100; f_exe = 32'h7000; MEM_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst req up", {31'h0, dm_if.dm_req}, 32'h1);
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst req drop", {31'h0, dm_if.dm_req}, 32'h0);
        check("rst over low", {31'h0, MEM_over}, 32'h0);
        check("rst state idle", 32'(dbg_state), 32'(S_IDLE));
        check("rst rdata_r", o_result, 32'h0);
        MEM_valid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        // -------- randomized ops against the model --------
        for (int i = 0; i < 60; i++) begin
            int kind;
            logic [4:0]  c;
            logic [31:0] a;
            kind = $urandom_range(0, 2);
            c = (kind == 0) ? 5'b0 : {kind == 1, kind == 2, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1))};
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            run_op(model_vec(c, a, $urandom, $urandom, $urandom_range(0, 3)), $urandom_range(0, 1),
                   $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
